// File: rtl/imm_ext_pkg.sv
// Shared types and defaults for the immediate-extension unit.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        IMM_SIGN   = 2'b00,
        IMM_ZERO   = 2'b01,
        IMM_UPPER  = 2'b10,
        IMM_BRANCH = 2'b11
    } imm_mode_t;

    localparam int N_DEF        = 32;
    localparam int BR_SHAMT_DEF = 2;
    localparam int TAG_W_DEF    = 5;

endpackage

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extender: sign, zero, upper-load and
// branch-offset (sign-extended, shifted left by BR_SHAMT).
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int I        = N / 2,
    parameter int BR_SHAMT = BR_SHAMT_DEF
) (
    input  logic [I-1:0] in_imm,
    input  imm_mode_t    in_mode,
    output logic [N-1:0] ext
);

    if ((I < 1) || (I > N)) begin : g_bad_i
        $error("imm_ext_core: I=%0d outside 1..N (N=%0d)", I, N);
    end
    if ((BR_SHAMT < 0) || (BR_SHAMT >= N)) begin : g_bad_shamt
        $error("imm_ext_core: BR_SHAMT=%0d outside 0..N-1", BR_SHAMT);
    end

    logic [N-1:0] sext;
    logic [N-1:0] zext;
    logic [N-1:0] upper;

    if (I < N) begin : g_narrow
        // Widen the immediate for each base form
        always_comb begin
            sext  = {{(N-I){in_imm[I-1]}}, in_imm};
            zext  = {{(N-I){1'b0}}, in_imm};
            upper = {in_imm, {(N-I){1'b0}}};
        end
    end else begin : g_full
        // Full-width immediate: every base form is the immediate itself
        always_comb begin
            sext  = in_imm;
            zext  = in_imm;
            upper = in_imm;
        end
    end

    // Select the extension form requested by the mode
    always_comb begin
        ext = sext;
        case (in_mode)
            IMM_SIGN:   ext = sext;
            IMM_ZERO:   ext = zext;
            IMM_UPPER:  ext = upper;
            IMM_BRANCH: ext = sext << BR_SHAMT;
            default:    ext = sext;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered ready/valid stage around imm_ext_core with a one-entry skid
// buffer (two entries total). in_ready is registered and never depends
// combinationally on out_ready.
// Optional macro IMM_EXT_PARITY_EN adds out_parity = ^out_data.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int I        = N / 2,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int BR_SHAMT = BR_SHAMT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [I-1:0]     in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
`ifdef IMM_EXT_PARITY_EN
    output logic             out_parity,
`endif
    output logic [TAG_W-1:0] out_tag
);

    logic [N-1:0]     ext;
    logic [N-1:0]     skid_data;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_valid;
    logic             skid_valid_nxt;
    logic             in_xfer;
    logic             drain;

    imm_ext_core #(
        .N        (N),
        .I        (I),
        .BR_SHAMT (BR_SHAMT)
    ) u_core (
        .in_imm  (in_imm),
        .in_mode (imm_mode_t'(in_mode)),
        .ext     (ext)
    );

    // Transfer qualifiers and skid occupancy for the next cycle
    always_comb begin
        in_xfer        = in_valid && in_ready;
        drain          = !out_valid || out_ready;
        // Draining always empties the skid: it moves into main, and while it
        // is full in_ready is low so no new item can race it.
        skid_valid_nxt = drain ? 1'b0 : (skid_valid || in_xfer);
    end

    // Main/skid storage and the registered ready flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_tag    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_tag   <= '0;
            in_ready   <= 1'b0;
        end else begin
            skid_valid <= skid_valid_nxt;
            in_ready   <= !skid_valid_nxt;
            if (drain) begin
                if (skid_valid) begin
                    out_data  <= skid_data;
                    out_tag   <= skid_tag;
                    out_valid <= 1'b1;
                end else if (in_xfer) begin
                    out_data  <= ext;
                    out_tag   <= in_tag;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (in_xfer) begin
                skid_data <= ext;
                skid_tag  <= in_tag;
            end
        end
    end

`ifdef IMM_EXT_PARITY_EN
    logic skid_parity;

    // Parity travels alongside data through main and skid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_parity  <= 1'b0;
            skid_parity <= 1'b0;
        end else if (drain) begin
            if (skid_valid) begin
                out_parity <= skid_parity;
            end else if (in_xfer) begin
                out_parity <= ^ext;
            end
        end else if (in_xfer) begin
            skid_parity <= ^ext;
        end
    end
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed steps plus a randomized
// phase, checked against a queue-based two-entry FIFO reference model.
module tb_imm_ext_pipe;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  t;
    } item_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    logic        in16_valid = 1'b0;
    logic        in16_ready;
    logic [7:0]  in16_imm = '0;
    logic [1:0]  in16_mode = '0;
    logic [4:0]  in16_tag = '0;
    logic        out16_valid;
    logic [15:0] out16_data;
    logic [4:0]  out16_tag;

`ifdef IMM_EXT_PARITY_EN
    logic        out_parity;
    logic        out16_parity;
`endif

    imm_ext_pipe #(.N(32), .I(16), .TAG_W(5), .BR_SHAMT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef IMM_EXT_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_tag   (out_tag)
    );

    imm_ext_pipe #(.N(16), .I(8), .TAG_W(5), .BR_SHAMT(1)) dut16 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in16_valid),
        .in_ready  (in16_ready),
        .in_imm    (in16_imm),
        .in_mode   (in16_mode),
        .in_tag    (in16_tag),
        .out_valid (out16_valid),
        .out_ready (1'b1),
        .out_data  (out16_data),
`ifdef IMM_EXT_PARITY_EN
        .out_parity(out16_parity),
`endif
        .out_tag   (out16_tag)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    item_t q[$];
    bit    m_rdy = 1'b0;

    // Arithmetic reference: value of the immediate as an integer, scaled.
    function automatic logic [31:0] ref_ext(input int n, input int i, input int sh,
                                            input longint imm, input int mode);
        longint s;
        longint r;
        longint mask;
        s = (imm >= (longint'(1) << (i - 1))) ? imm - (longint'(1) << i) : imm;
        case (mode)
            0:       r = s;
            1:       r = imm;
            2:       r = imm * (longint'(1) << (n - i));
            default: r = s * (longint'(1) << sh);
        endcase
        mask = (longint'(1) << n) - 1;
        return 32'(r & mask);
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", 64'(in_ready), 64'(m_rdy && (q.size() < 2)));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_data", 64'(out_data), 64'(q[0].d));
            chk("out_tag", 64'(out_tag), 64'(q[0].t));
`ifdef IMM_EXT_PARITY_EN
            chk("out_parity", 64'(out_parity), 64'(^q[0].d));
`endif
        end
    endtask

    // One clock: update the model from the inputs seen at the edge, then
    // compare on the falling edge.
    task automatic step();
        int    n0;
        item_t it;
        @(posedge clk);
        if (!m_rdy) begin
            m_rdy = 1'b1;
        end else begin
            n0   = q.size();
            it.d = ref_ext(32, 16, 2, longint'(in_imm), int'(in_mode));
            it.t = in_tag;
            if (n0 > 0 && out_ready) void'(q.pop_front());
            if (in_valid && n0 < 2) q.push_back(it);
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        q.delete();
        m_rdy = 1'b0;
        #1 reset = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] imm, input logic [1:0] mode,
                        input logic [4:0] tag, input logic [31:0] exp);
        in_valid  = 1'b1;
        in_imm    = imm;
        in_mode   = mode;
        in_tag    = tag;
        out_ready = 1'b1;
        step();
        chk("mode_literal", 64'(out_data), 64'(exp));
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] held;

        // Power-on reset, then ready one edge after release
        do_reset();
        step();
        chk("ready_after_reset", 64'(in_ready), 64'd1);

        // One item per mode, each visible one cycle after acceptance
        send(16'h8000, 2'b00, 5'd1, 32'hFFFF8000);
`ifdef IMM_EXT_PARITY_EN
        chk("parity_literal", 64'(out_parity), 64'd1);
`endif
        send(16'h1402, 2'b01, 5'd2, 32'h00001402);
        send(16'h24B7, 2'b10, 5'd3, 32'h24B70000);
        send(16'hFFFF, 2'b11, 5'd4, 32'hFFFFFFFC);
        step();

        // Streaming: back-to-back SIGN items at full rate
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_imm   = 16'($urandom);
            in_mode  = 2'b00;
            in_tag   = 5'(i);
            step();
            chk("stream_tag", 64'(out_tag), 64'(i));
            chk("stream_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        step();

        // Backpressure: two accepted, third held while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_imm    = 16'h1111; in_tag = 5'd1; step();
        in_imm    = 16'h2222; in_tag = 5'd2; step();
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        held = out_data;
        in_imm = 16'h3333; in_tag = 5'd3;
        step();
        step();
        chk("bp_stall_data", 64'(out_data), 64'(held));
        chk("bp_stall_tag", 64'(out_tag), 64'd1);
        out_ready = 1'b1;
        step();
        chk("bp_drain_2", 64'(out_tag), 64'd2);
        step();
        chk("bp_drain_3", 64'(out_tag), 64'd3);
        in_valid = 1'b0;
        step();
        step();

        // Reset mid-operation with both entries full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_imm = 16'hABCD; in_tag = 5'd9;  step();
        in_imm = 16'h0F0F; in_tag = 5'd10; step();
        do_reset();
        out_ready = 1'b1;
        step();
        chk("midrst_ready", 64'(in_ready), 64'd1);
        chk("midrst_no_stale", 64'(out_valid), 64'd0);
        step();

        // Parametric instance: N=16, I=8, BR_SHAMT=1
        in16_valid = 1'b1;
        in16_imm = 8'h80; in16_mode = 2'b11; in16_tag = 5'd5;
        step();
        chk("p16_branch", 64'(out16_data), 64'h0000_0000_0000_FF00);
        chk("p16_branch_ref", 64'(out16_data), 64'(16'(ref_ext(16, 8, 1, 64'h80, 3))));
        in16_imm = 8'h7F; in16_mode = 2'b10; in16_tag = 5'd6;
        step();
        chk("p16_upper", 64'(out16_data), 64'h0000_0000_0000_7F00);
        chk("p16_tag", 64'(out16_tag), 64'd6);
        in16_valid = 1'b0;
        step();

        // Randomized traffic against the FIFO model
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom_range(0, 3));
            in_tag    = 5'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
Parametrised immediate-extension unit with a registered ready/valid pipeline stage and a skid buffer. It supports four extension modes: sign, zero, upper-load and branch-offset shift. It replaces the purely combinational sign extender between the decode stage and the ALU/branch-target path of the 32-bit CPU. Each immediate carries a tag (destination/instruction id) that travels with it, so decode can stall independently of execute.

Parameters:
N, 32, output operand width in bits
I, N/2, immediate input width in bits; legal range 1 <= I <= N (elaboration $error otherwise)
TAG_W, 5, width of the sideband tag carried with each immediate
BR_SHAMT, 2, left-shift amount applied in BRANCH mode; legal range 0 <= BR_SHAMT < N

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream presents an immediate
in_ready  output  1  unit can accept an immediate this cycle
in_imm  input  I  raw immediate field
in_mode  input  2  extension mode (imm_mode_t)
in_tag  input  TAG_W  sideband tag
out_valid  output  1  out_data/out_tag hold a valid result
out_ready  input  1  downstream accepts the result this cycle
out_data  output  N  extended immediate
out_tag  output  TAG_W  tag matching out_data

Behaviour:
- Reset: asynchronous and active-high, as already decided.
  - While reset is high: out_valid=0, out_data=0, out_tag=0, skid_valid=0, in_ready=0.
  - From the first clk edge after reset deasserts: in_ready=1.
- Extension is combinational from in_imm and in_mode; the result is registered.
  - SIGN (2'b00): out = {{(N-I){imm[I-1]}}, imm}.
  - ZERO (2'b01): out = {{(N-I){1'b0}}, imm}.
  - UPPER (2'b10): out = imm << (N-I), low N-I bits zero. When I==N, the result equals imm.
  - BRANCH (2'b11): out = SIGN(imm) << BR_SHAMT, truncated to N bits; the BR_SHAMT LSBs are zero.
- Handshake:
  - An input transfer occurs on an edge where in_valid && in_ready.
  - An output transfer occurs on an edge where out_valid && out_ready.
- Storage: one main output register plus one skid register, 2 entries total.
  - in_ready = !skid_valid (registered, no combinational path from out_ready).
- Latency and throughput: an item accepted at edge k is visible on out_data after edge k (1 cycle). Sustained throughput is 1 item/cycle while out_ready=1.
- Per-edge update rules:
  - Main empty or main drained (out_ready=1): main loads from skid if skid_valid, else from the input transfer, else clears out_valid.
  - Main full and not drained, with an input transfer: the input goes into skid and skid_valid becomes 1.
  - Skid drained into main with a simultaneous input transfer: not possible, because in_ready=0 while skid_valid=1.
- Full: when both entries are valid, in_ready=0 and in_imm is ignored.
- Empty: out_valid=0. out_data holds its last value; do not zero it.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_tag must not change.
- Ordering: strict FIFO order; tags never reorder.
- Reset mid-operation: both entries are discarded immediately. No partial transfer is reported.
- in_mode values are all legal; there is no error path.

Optional Feature:
- Macro: IMM_EXT_PARITY_EN.
- When defined:
  - Adds output port out_parity (1 bit) = ^out_data, registered with out_data.
  - Adds a parity bit to the skid entry.
  - out_parity resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package imm_ext_pkg holds:
  - typedef enum logic [1:0] imm_mode_t {IMM_SIGN, IMM_ZERO, IMM_UPPER, IMM_BRANCH}
  - localparam defaults N_DEF=32 and BR_SHAMT_DEF=2
- Sub-module imm_ext_core: purely combinational extender (in_imm, in_mode -> ext). It is reusable by the existing single-cycle datapath.
- imm_ext_pipe contains only the handshake and storage logic.

Test Plan:
- Mode check, N=32, I=16, out_ready=1, one item per mode:
  - 0x8000 SIGN -> 0xFFFF8000
  - 0x1402 ZERO -> 0x00001402
  - 0x24B7 UPPER -> 0x24B70000
  - 0xFFFF BRANCH -> 0xFFFFFFFC
  - Each result appears 1 cycle after acceptance.
- Streaming: 8 back-to-back SIGN items, tags 0..7, out_ready=1 -> 8 outputs on consecutive cycles, tags in order, in_ready stays 1.
- Backpressure: out_ready=0, present tags 1,2,3 -> tags 1 and 2 accepted, in_ready=0 on the cycle after the second accept, tag 3 held.
  - Raise out_ready -> outputs 1,2,3 in order, with out_data stable during the stall.
- Reset mid-operation: fill both entries, pulse reset asynchronously between edges -> out_valid=0 and out_data=0 immediately, no stale output afterwards, in_ready=1 one edge after release.
- Parametric: N=16, I=8, BR_SHAMT=1, input 0x80 BRANCH -> 0xFF00; 0x7F UPPER -> 0x7F00.
- Parity build (IMM_EXT_PARITY_EN defined): 0x8000 SIGN -> out_data 0xFFFF8000, out_parity 1.
